match_controller: RTL
=====================

Name: match_controller

Overview:
- Sequences a two-player fight match: countdown, fight rounds, round scoring, match end.
- Sits above the two player modules and owns their round reset.
- Paces play with a game tick and presents sanitized one-hot actions for one cycle per tick.
- Monitors both player health values to decide knockouts, timeouts and round wins.

Parameters:
- TICK_DIV, 4: clk cycles per game tick (>=2).
- COUNTDOWN_TICKS, 3: ticks spent in COUNTDOWN before each round.
- ROUND_TICKS, 30: action ticks per round before timeout (<=63).
- ROUNDS_TO_WIN, 2: round wins that end the match (<=3).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  start-match pulse; honoured only in IDLE or MATCH_OVER.
- left_req  in  6  raw left-player action request.
- right_req  in  6  raw right-player action request.
- left_health  in  3  left player health (present state).
- right_health  in  3  right player health (present state).
- left_action  out  6  action issued to left player.
- right_action  out  6  action issued to right player.
- action_valid  out  1  one-cycle pulse; actions are live this cycle.
- round_rst_n  out  1  active-low reset to both player modules.
- state  out  3  FSM state.
- round_timer  out  6  remaining action ticks in the round.
- left_wins  out  2  left round wins.
- right_wins  out  2  right round wins.
- round_result  out  2  last round result: 00 none, 01 left, 10 right, 11 draw.
- match_over  out  1  high in MATCH_OVER.

Behaviour:
- Actions are one-hot: RIGHT 100000, LEFT 010000, WAIT 001000, JUMP 000100, KICK 000010, PUNCH 000001.
- Sanitize: any request that is not exactly one-hot (including zero) becomes WAIT.
- Reset values:
  - state IDLE, tick counter 0.
  - left_action and right_action = WAIT, action_valid 0, round_rst_n 0.
  - round_timer 0, wins 0, round_result 00, match_over 0.
- Tick counter:
  - Counts 0..TICK_DIV-1; tick is high when count == TICK_DIV-1.
  - Clears to 0 on every state transition.
- Outside an issuing edge, the action outputs hold WAIT. The players run every clk, so only one cycle per tick carries a real action.
- KO: a health value is KO when it is 0 or >= 6, which covers underflow wrap.
- IDLE: round_rst_n=0. On start: clear wins and round_result, go to COUNTDOWN.
- COUNTDOWN: round_rst_n=0.
  - After COUNTDOWN_TICKS ticks: load round_timer=ROUND_TICKS, go to FIGHT.
  - round_rst_n goes to 1 on the same edge.
- FIGHT: round_rst_n=1. On each tick, evaluate in priority order:
  1. Both KO: result draw (11), no win.
  2. One KO: the other player wins; its win count +1.
  3. round_timer==0: higher health wins (+1 win); equal health is a draw.
  4. Otherwise, on the next edge: register the sanitized requests, pulse action_valid for 1 cycle, decrement round_timer.
- Cases 1–3 load round_result and go to ROUND_END; no action is issued on that tick.
- Latency: requests sampled at a tick edge appear on the outputs for exactly the following cycle.
- ROUND_END: round_rst_n=1, holding final health for observation. Stay for one tick, then:
  - If either win count == ROUNDS_TO_WIN, go to MATCH_OVER.
  - Otherwise go to COUNTDOWN.
- MATCH_OVER: match_over=1; round_result and wins held. On start: clear wins, go to COUNTDOWN.
- start is ignored in COUNTDOWN, FIGHT and ROUND_END.
- Draws award no win; unlimited rounds are permitted.
- Win counters saturate at ROUNDS_TO_WIN.
- Reset mid-operation: all state returns to reset values immediately (asynchronous).
- State encoding: IDLE 0, COUNTDOWN 1, FIGHT 2, ROUND_END 3, MATCH_OVER 4.

Decomposition:
- Shared game package holds:
  - the six action constants and the WAIT default;
  - FSM state encodings;
  - round_result encodings;
  - the KO predicate as a function.
- One natural sub-module: game_tick_gen. It is the parameterized divider with synchronous clear, producing the tick.

Test Plan (TICK_DIV=4, COUNTDOWN_TICKS=3, ROUND_TICKS=5, ROUNDS_TO_WIN=2):
- Reset, then start pulse: round_rst_n low for 12 cycles of COUNTDOWN, then state=2, round_timer=5, round_rst_n=1.
- FIGHT with left_req=000011, right_req=000000: outputs WAIT/WAIT with a 1-cycle action_valid every 4 cycles, WAIT otherwise; round_timer 5→4.
- right_health driven 0 at a tick: round_result=01, left_wins=1, no action_valid that tick; ROUND_END lasts 4 cycles, then COUNTDOWN.
- Timeout with healths 3/2 after 5 actions: at the 6th tick round_result=01. Timeout at 2/2 gives round_result=11 with wins unchanged.
- left wins twice: state=4, match_over=1, left_wins=2. start mid-FIGHT is ignored; start in MATCH_OVER gives wins=0, state=1.
- left_health=7 with right_health=6 at a tick gives draw 11. rst_n low mid-FIGHT immediately restores all reset values.

Source files
------------

// File: rtl/match_controller_pkg.sv
// Shared game definitions: action encodings, FSM and result encodings,
// and the small predicates used by the match sequencer.
package match_controller_pkg;

    localparam int ACT_W = 6;

    localparam logic [ACT_W-1:0] ACT_RIGHT   = 6'b100000;
    localparam logic [ACT_W-1:0] ACT_LEFT    = 6'b010000;
    localparam logic [ACT_W-1:0] ACT_WAIT    = 6'b001000;
    localparam logic [ACT_W-1:0] ACT_JUMP    = 6'b000100;
    localparam logic [ACT_W-1:0] ACT_KICK    = 6'b000010;
    localparam logic [ACT_W-1:0] ACT_PUNCH   = 6'b000001;
    localparam logic [ACT_W-1:0] ACT_DEFAULT = ACT_WAIT;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_COUNTDOWN  = 3'd1,
        ST_FIGHT      = 3'd2,
        ST_ROUND_END  = 3'd3,
        ST_MATCH_OVER = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE  = 2'b00,
        RES_LEFT  = 2'b01,
        RES_RIGHT = 2'b10,
        RES_DRAW  = 2'b11
    } result_t;

    // Health of 6 or 7 can only come from an underflow wrap, so it counts as KO.
    function automatic logic is_ko(input logic [2:0] health);
        return (health == 3'd0) || (health >= 3'd6);
    endfunction

    function automatic logic [ACT_W-1:0] sanitize(input logic [ACT_W-1:0] req);
        if ((req != '0) && ((req & (req - 6'd1)) == '0))
            return req;
        return ACT_DEFAULT;
    endfunction

endpackage

// File: rtl/match_controller_tick_gen.sv
// Game tick divider: tick is high in the last cycle of every TICK_DIV-cycle
// period; a synchronous clear restarts the period.
module game_tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear || (count == LAST))
            count <= '0;
        else
            count <= count + CW'(1);
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/match_controller.sv
// Two-player match sequencer: countdown, paced fight rounds, round scoring
// and match end. Owns the players' round reset and issues one action per tick.
module match_controller
    import match_controller_pkg::*;
#(
    parameter int TICK_DIV        = 4,
    parameter int COUNTDOWN_TICKS = 3,
    parameter int ROUND_TICKS     = 30,
    parameter int ROUNDS_TO_WIN   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ACT_W-1:0] left_req,
    input  logic [ACT_W-1:0] right_req,
    input  logic [2:0]       left_health,
    input  logic [2:0]       right_health,
    output logic [ACT_W-1:0] left_action,
    output logic [ACT_W-1:0] right_action,
    output logic             action_valid,
    output logic             round_rst_n,
    output logic [2:0]       state,
    output logic [5:0]       round_timer,
    output logic [1:0]       left_wins,
    output logic [1:0]       right_wins,
    output logic [1:0]       round_result,
    output logic             match_over
);

    localparam int CD_W = (COUNTDOWN_TICKS > 1) ? $clog2(COUNTDOWN_TICKS) : 1;
    localparam logic [CD_W-1:0] CD_LAST    = CD_W'(COUNTDOWN_TICKS - 1);
    localparam logic [1:0]      WIN_TARGET = 2'(ROUNDS_TO_WIN);

    state_t           state_q, state_d;
    logic [CD_W-1:0]  cd_q, cd_d;
    logic [5:0]       timer_d;
    logic [1:0]       lw_d, rw_d, res_d;
    logic [ACT_W-1:0] left_act_d, right_act_d;
    logic             valid_d, rrst_d;
    logic             left_ko, right_ko;
    logic             tick, tick_clear;

    function automatic logic [1:0] win_inc(input logic [1:0] w);
        return (w >= WIN_TARGET) ? w : w + 2'd1;
    endfunction

    game_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (tick_clear),
        .tick  (tick)
    );

    // Every state change restarts the tick period so each state lasts whole ticks.
    assign tick_clear = (state_d != state_q);

    always_comb begin
        state_d     = state_q;
        cd_d        = cd_q;
        timer_d     = round_timer;
        lw_d        = left_wins;
        rw_d        = right_wins;
        res_d       = round_result;
        left_act_d  = ACT_DEFAULT;
        right_act_d = ACT_DEFAULT;
        valid_d     = 1'b0;
        left_ko     = is_ko(left_health);
        right_ko    = is_ko(right_health);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    lw_d    = '0;
                    rw_d    = '0;
                    res_d   = RES_NONE;
                    state_d = ST_COUNTDOWN;
                end
            end
            ST_COUNTDOWN: begin
                if (tick) begin
                    if (cd_q == CD_LAST) begin
                        timer_d = 6'(ROUND_TICKS);
                        state_d = ST_FIGHT;
                    end else begin
                        cd_d = cd_q + CD_W'(1);
                    end
                end
            end
            ST_FIGHT: begin
                if (tick) begin
                    if (left_ko && right_ko) begin
                        res_d   = RES_DRAW;
                        state_d = ST_ROUND_END;
                    end else if (left_ko) begin
                        res_d   = RES_RIGHT;
                        rw_d    = win_inc(right_wins);
                        state_d = ST_ROUND_END;
                    end else if (right_ko) begin
                        res_d   = RES_LEFT;
                        lw_d    = win_inc(left_wins);
                        state_d = ST_ROUND_END;
                    end else if (round_timer == 6'd0) begin
                        if (left_health > right_health) begin
                            res_d = RES_LEFT;
                            lw_d  = win_inc(left_wins);
                        end else if (right_health > left_health) begin
                            res_d = RES_RIGHT;
                            rw_d  = win_inc(right_wins);
                        end else begin
                            res_d = RES_DRAW;
                        end
                        state_d = ST_ROUND_END;
                    end else begin
                        left_act_d  = sanitize(left_req);
                        right_act_d = sanitize(right_req);
                        valid_d     = 1'b1;
                        timer_d     = round_timer - 6'd1;
                    end
                end
            end
            ST_ROUND_END: begin
                if (tick)
                    state_d = ((left_wins == WIN_TARGET) || (right_wins == WIN_TARGET))
                              ? ST_MATCH_OVER : ST_COUNTDOWN;
            end
            ST_MATCH_OVER: begin
                if (start) begin
                    lw_d    = '0;
                    rw_d    = '0;
                    state_d = ST_COUNTDOWN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != ST_COUNTDOWN)
            cd_d = '0;
        // Players run only while fighting or while final health is on display.
        rrst_d = (state_d == ST_FIGHT) || (state_d == ST_ROUND_END);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cd_q         <= '0;
            round_timer  <= '0;
            left_wins    <= '0;
            right_wins   <= '0;
            round_result <= RES_NONE;
            left_action  <= ACT_DEFAULT;
            right_action <= ACT_DEFAULT;
            action_valid <= 1'b0;
            round_rst_n  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cd_q         <= cd_d;
            round_timer  <= timer_d;
            left_wins    <= lw_d;
            right_wins   <= rw_d;
            round_result <= res_d;
            left_action  <= left_act_d;
            right_action <= right_act_d;
            action_valid <= valid_d;
            round_rst_n  <= rrst_d;
        end
    end

    assign state      = state_q;
    assign match_over = (state_q == ST_MATCH_OVER);

endmodule
